inst_sequencer: RTL
===================

// Module: inst_sequencer
// PURPOSE
//  Cycle sequencer for the Nandy core. Holds the instruction register and drives
//  the control decoder's inst/cycle/ncycle inputs. Runs memory-class ops
//  (inst[7]=1) as two cycles and stretches I/O ops (decoder RD/WR) until the
//  device acknowledges. Takes interrupts at instruction boundaries.
//  Outputs fetch/commit strobes that gate PC advance and register/memory writes.
// PARAMETERS
//  NOP_OPCODE  8'h00  instruction register value while in reset/BOOT
//  INT_OPCODE  8'h10  opcode injected on interrupt entry (link-jump)
//  IO_TIMEOUT  16     max IOWAIT cycles before forced completion; 0 = no timeout
// PORTS
//  clk      in   1  single clock, rising edge
//  rst      in   1  synchronous, active-high reset
//  hold     in   1  external stall (debug/single-step); freezes all state
//  inst_in  in   8  next instruction byte from program memory at current PC
//  io_rd    in   1  decoder RD for current inst/cycle
//  io_wr    in   1  decoder WR for current inst/cycle
//  ncli     in   1  decoder nCLI, active low; re-arms interrupts at commit
//  irq      in   1  level interrupt request
//  io_ack   in   1  I/O device acknowledge
//  inst     out  8  instruction register -> decoder inst
//  cycle    out  1  0 = first cycle, 1 = second cycle of a memory-class op
//  ncycle   out  1  always ~cycle
//  fetch    out  1  PC advances and inst loads from inst_in at this edge
//  commit   out  1  final cycle of an instruction; core enables writes only here
//  io_req   out  1  I/O request, registered, high throughout IOWAIT
//  io_err   out  1  sticky: an I/O op timed out; cleared only by rst
//  int_ack  out  1  one-cycle pulse: interrupt accepted at this edge
//  ie       out  1  interrupt enable flag
// BEHAVIOUR
//  States: BOOT, EXEC0 (cycle=0), EXEC1 (cycle=1), IOWAIT (cycle=0).
//  Reset: state=BOOT, inst=NOP_OPCODE, ie=0, io_err=0, counter=0. All strobes are 0
//   during rst. cycle=0, ncycle=1.
//  hold=1 (any non-reset state): no register changes. fetch/commit/int_ack/io_req
//   keep the state's value except that fetch=commit=int_ack=0. io_req stays high
//   if in IOWAIT. rst overrides hold.
//  BOOT: fetch=1, commit=0; next EXEC0, inst<=inst_in.
//  EXEC0: inst[7]=1 -> EXEC1, no strobes.
//   else io_rd|io_wr -> IOWAIT, counter<=0, no strobes.
//   else complete.
//  EXEC1: complete.
//  IOWAIT: io_req=1. io_ack=1 -> complete. Else if IO_TIMEOUT!=0 and
//   counter==IO_TIMEOUT-1 -> io_err<=1, complete. Else counter++.
//   Ack on the timeout cycle counts as success, so io_err is unchanged.
//  Complete (same cycle): commit=1. Any completion returns to EXEC0 next cycle.
//   If ncli=0 then ie<=1.
//   If irq & ie (ie sampled before this cycle's update): fetch=0, int_ack=1,
//    ie<=0, inst<=INT_OPCODE (PC not advanced; core links the current PC).
//   Else: fetch=1, inst<=inst_in.
//   A re-arm and an irq in the same commit do not take the interrupt until the
//    next boundary.
//  io_req is registered: it rises on the first IOWAIT cycle and falls the cycle
//   after completion. The device holds io_ack until io_req falls. An ack outside
//   IOWAIT is ignored.
//  Latency: plain op 1 cycle. inst[7] op 2 cycles. I/O op 1 + N wait cycles,
//   N>=1 and N<=IO_TIMEOUT.
//  Counter width: $clog2(IO_TIMEOUT+1), min 1. Never wraps: leaves IOWAIT at the limit.
// TESTING
//  1 rst 3 cycles, inst_in=8'h45 -> inst=00, fetch=1 in BOOT, then inst=45, cycle=0,
//    commit=1 one cycle later.
//  2 inst_in=8'h80 -> cycle 0 then 1, commit only in the cycle=1 cycle, one fetch.
//  3 inst_in=8'h04 (RD), io_ack asserted on 3rd IOWAIT cycle -> io_req high 3
//    cycles, commit once, io_err=0.
//  4 IO_TIMEOUT=4, inst 8'h08 (WR), no ack -> 4 IOWAIT cycles, io_err=1 stays,
//    next inst fetched.
//  5 ie=1 via ncli=0 commit, irq=1 -> next boundary int_ack=1, fetch=0,
//    inst=8'h10, ie=0, irq ignored afterwards.
//  6 hold=1 mid-IOWAIT with io_ack=1 -> no completion; rst during EXEC1 -> BOOT,
//    inst=00, io_req=0.

Source files
------------

// File: rtl/inst_sequencer.sv
// Cycle sequencer for the Nandy core: owns the instruction register, steps
// memory-class ops through two cycles, stretches I/O ops until acknowledged
// and injects the interrupt opcode at instruction boundaries.
module inst_sequencer #(
  parameter logic [7:0] NOP_OPCODE = 8'h00,
  parameter logic [7:0] INT_OPCODE = 8'h10,
  parameter int         IO_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic [7:0] inst_in,
  input  logic       io_rd,
  input  logic       io_wr,
  input  logic       ncli,
  input  logic       irq,
  input  logic       io_ack,
  output logic [7:0] inst,
  output logic       cycle,
  output logic       ncycle,
  output logic       fetch,
  output logic       commit,
  output logic       io_req,
  output logic       io_err,
  output logic       int_ack,
  output logic       ie
);

  localparam int CW = (IO_TIMEOUT > 0) ? $clog2(IO_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((IO_TIMEOUT > 0) ? IO_TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {BOOT, EXEC0, EXEC1, IOWAIT} state_t;

  state_t        state;
  logic [CW-1:0] waitCnt;
  logic          done;
  logic          timeout;
  logic          take;
  logic          active;

  assign cycle  = (state == EXEC1);
  assign ncycle = ~cycle;

  // Completion / interrupt decision for the current cycle and the strobes
  // derived from it; strobes are suppressed during reset and hold.
  always_comb begin
    done    = 1'b0;
    timeout = 1'b0;
    case (state)
      EXEC0:  done = ~inst[7] & ~(io_rd | io_wr);
      EXEC1:  done = 1'b1;
      IOWAIT: begin
        if (io_ack) begin
          done = 1'b1;
        end else if ((IO_TIMEOUT != 0) && (waitCnt == CNT_LAST)) begin
          done    = 1'b1;
          timeout = 1'b1;
        end
      end
      default: done = 1'b0;
    endcase
    take    = done & irq & ie;
    active  = ~rst & ~hold;
    commit  = active & done;
    int_ack = active & take;
    fetch   = active & ((state == BOOT) | (done & ~take));
  end

  // Sequencer state, instruction register, interrupt enable and I/O tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOOT;
      inst    <= NOP_OPCODE;
      ie      <= 1'b0;
      io_err  <= 1'b0;
      io_req  <= 1'b0;
      waitCnt <= '0;
    end else if (!hold) begin
      case (state)
        BOOT: begin
          state <= EXEC0;
          inst  <= inst_in;
        end
        EXEC0: begin
          if (inst[7]) begin
            state <= EXEC1;
          end else if (io_rd | io_wr) begin
            state   <= IOWAIT;
            waitCnt <= '0;
            io_req  <= 1'b1;
          end
        end
        IOWAIT: begin
          // saturate rather than wrap; only reachable with no timeout
          if (!done && waitCnt != CNT_MAX) waitCnt <= waitCnt + 1'b1;
        end
        default: ;
      endcase
      if (done) begin
        state  <= EXEC0;
        io_req <= 1'b0;
        if (timeout) io_err <= 1'b1;
        if (!ncli) ie <= 1'b1;
        // accepting an interrupt disables further ones, even over a re-arm
        if (take) begin
          ie   <= 1'b0;
          inst <= INT_OPCODE;
        end else begin
          inst <= inst_in;
        end
      end
    end
  end

endmodule
